// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx
// Description : 8N1 UART receiver with two-flop input synchronizer and
//               pulsed byte/frame/parity status. Optional even-parity
//               bit enabled by defining SERIAL_RX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_rx #(
    parameter int CLKS_PER_BIT = 96
) (
    input  logic       clk_usb,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] reg_usb_data_in,
    output logic       byte_ready,
    output logic       frame_error,
    output logic       parity_error,
    output logic       rx_busy
);

    localparam logic [15:0] c_HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] c_FULL_M1 = 16'(CLKS_PER_BIT - 1);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_START     = 3'd1;
    localparam logic [2:0] c_S_DATA      = 3'd2;
    localparam logic [2:0] c_S_STOP      = 3'd3;
    localparam logic [2:0] c_S_WAIT_HIGH = 3'd4;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [2:0] c_S_PARITY    = 3'd5;
`endif

    logic        r_rx_meta;
    logic        r_rx_s;
    logic [2:0]  r_state;
    logic [2:0]  w_state;
    logic [15:0] r_timer;
    logic [15:0] w_timer;
    logic [2:0]  r_index;
    logic [2:0]  w_index;
    logic [7:0]  r_shift;
    logic [7:0]  w_shift;
    logic [7:0]  r_data;
    logic [7:0]  w_data;
    logic        r_byte_ready;
    logic        w_byte_ready;
    logic        r_frame_error;
    logic        w_frame_error;
`ifdef SERIAL_RX_PARITY_EN
    logic        r_parity_bit;
    logic        w_parity_bit;
    logic        r_parity_error;
    logic        w_parity_error;
    logic        w_parity_ok;
`endif

    // Synchronizer idles at 1 so reset release never looks like a start bit
    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            r_state        <= c_S_IDLE;
            r_timer        <= 16'd0;
            r_index        <= 3'd0;
            r_shift        <= 8'd0;
            r_data         <= 8'd0;
            r_byte_ready   <= 1'b0;
            r_frame_error  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_parity_bit   <= 1'b0;
            r_parity_error <= 1'b0;
`endif
        end else begin
            r_state        <= w_state;
            r_timer        <= w_timer;
            r_index        <= w_index;
            r_shift        <= w_shift;
            r_data         <= w_data;
            r_byte_ready   <= w_byte_ready;
            r_frame_error  <= w_frame_error;
`ifdef SERIAL_RX_PARITY_EN
            r_parity_bit   <= w_parity_bit;
            r_parity_error <= w_parity_error;
`endif
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    // Even parity: data bits plus parity bit must XOR to zero
    assign w_parity_ok = ~(^r_shift ^ r_parity_bit);
`endif

    always_comb begin
        w_state       = r_state;
        w_timer       = r_timer;
        w_index       = r_index;
        w_shift       = r_shift;
        w_data        = r_data;
        w_byte_ready  = 1'b0;
        w_frame_error = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        w_parity_bit   = r_parity_bit;
        w_parity_error = 1'b0;
`endif
        case (r_state)
            c_S_IDLE: begin
                if (!r_rx_s) begin
                    w_state = c_S_START;
                    w_timer = 16'd0;
                end
            end
            c_S_START: begin
                if (r_timer == c_HALF_M1) begin
                    w_timer = 16'd0;
                    w_index = 3'd0;
                    w_state = r_rx_s ? c_S_IDLE : c_S_DATA;
                end else begin
                    w_timer = r_timer + 16'd1;
                end
            end
            c_S_DATA: begin
                if (r_timer == c_FULL_M1) begin
                    w_timer          = 16'd0;
                    w_shift[r_index] = r_rx_s;
                    if (r_index == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                        w_state = c_S_PARITY;
`else
                        w_state = c_S_STOP;
`endif
                    end else begin
                        w_index = r_index + 3'd1;
                    end
                end else begin
                    w_timer = r_timer + 16'd1;
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            c_S_PARITY: begin
                if (r_timer == c_FULL_M1) begin
                    w_timer      = 16'd0;
                    w_parity_bit = r_rx_s;
                    w_state      = c_S_STOP;
                end else begin
                    w_timer = r_timer + 16'd1;
                end
            end
`endif
            c_S_STOP: begin
                if (r_timer == c_FULL_M1) begin
                    w_timer = 16'd0;
                    // A bad stop bit wins over a parity mismatch
                    if (!r_rx_s) begin
                        w_frame_error = 1'b1;
                        w_state       = c_S_WAIT_HIGH;
                    end else begin
                        w_state = c_S_IDLE;
`ifdef SERIAL_RX_PARITY_EN
                        if (w_parity_ok) begin
                            w_byte_ready = 1'b1;
                            w_data       = r_shift;
                        end else begin
                            w_parity_error = 1'b1;
                        end
`else
                        w_byte_ready = 1'b1;
                        w_data       = r_shift;
`endif
                    end
                end else begin
                    w_timer = r_timer + 16'd1;
                end
            end
            c_S_WAIT_HIGH: begin
                if (r_rx_s) begin
                    w_state = c_S_IDLE;
                end
            end
            default: begin
                w_state = c_S_IDLE;
                w_timer = 16'd0;
                w_index = 3'd0;
            end
        endcase
    end

    assign reg_usb_data_in = r_data;
    assign byte_ready      = r_byte_ready;
    assign frame_error     = r_frame_error;
    assign rx_busy         = (r_state != c_S_IDLE);
`ifdef SERIAL_RX_PARITY_EN
    assign parity_error    = r_parity_error;
`else
    assign parity_error    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_rx
// Description : Scoreboard bench for serial_rx at CLKS_PER_BIT=16; parity
//               scenarios are built when SERIAL_RX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_rx;

    localparam int c_CPB = 16;

    logic       clk_usb;
    logic       reset;
    logic       rx;
    logic [7:0] reg_usb_data_in;
    logic       byte_ready;
    logic       frame_error;
    logic       parity_error;
    logic       rx_busy;

    int         total;
    int         bad;
    int         cnt_byte;
    int         cnt_ferr;
    int         cnt_perr;
    int         busy_cyc;
    logic [7:0] exp_q[$];

    serial_rx #(.CLKS_PER_BIT(c_CPB)) dut (
        .clk_usb         (clk_usb),
        .reset           (reset),
        .rx              (rx),
        .reg_usb_data_in (reg_usb_data_in),
        .byte_ready      (byte_ready),
        .frame_error     (frame_error),
        .parity_error    (parity_error),
        .rx_busy         (rx_busy)
    );

    initial clk_usb = 1'b0;
    always #5 clk_usb = ~clk_usb;

    // Monitor: pops the scoreboard on each byte_ready, counts pulses
    always @(negedge clk_usb) begin
        if (!reset) begin
            if (rx_busy) busy_cyc++;
            if (frame_error) cnt_ferr++;
            if (parity_error) cnt_perr++;
            if (byte_ready || frame_error || parity_error) begin
                total++;
                if ((32'(byte_ready) + 32'(frame_error) + 32'(parity_error)) != 1) begin
                    bad++;
                    $display("FAIL pulse_overlap: got br=%b fe=%b pe=%b, want exactly one",
                             byte_ready, frame_error, parity_error);
                end
            end
            if (byte_ready) begin
                cnt_byte++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_byte: got %02h, want no byte", reg_usb_data_in);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (reg_usb_data_in !== e) begin
                        bad++;
                        $display("FAIL byte_data: got %02h, want %02h", reg_usb_data_in, e);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_usb);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        idle(c_CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        send_bit(par);
`else
        if (par) begin end
`endif
        send_bit(stop);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, ^d, 1'b1);
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic test_reset;
        rx    = 1'b1;
        reset = 1'b1;
        idle(3);
        check_int("reset_data", int'(reg_usb_data_in), 0);
        check_int("reset_busy", int'(rx_busy), 0);
        check_int("reset_pulses", int'({byte_ready, frame_error, parity_error}), 0);
        reset = 1'b0;
        idle(5);
        check_int("release_busy", int'(rx_busy), 0);
    endtask

    task automatic test_valid_byte;
        int b0;
        int f0;
        b0 = cnt_byte;
        f0 = cnt_ferr;
        busy_cyc = 0;
        exp_q.push_back(8'hC3);
        send_byte(8'hC3);
        idle(c_CPB);
        check_int("c3_bytes", cnt_byte - b0, 1);
        check_int("c3_ferr", cnt_ferr - f0, 0);
        check_int("c3_data", int'(reg_usb_data_in), 'hC3);
        // 8 cycles of start half-bit, 8 data bits, 1 stop bit
        total++;
        if (busy_cyc < 150 || busy_cyc > 154) begin
            bad++;
            $display("FAIL c3_busy_len: got %0d cycles, want 150..154", busy_cyc);
        end
    endtask

    task automatic test_glitch;
        int b0;
        int f0;
        int p0;
        b0 = cnt_byte;
        f0 = cnt_ferr;
        p0 = cnt_perr;
        busy_cyc = 0;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(3 * c_CPB);
        check_int("glitch_bytes", cnt_byte - b0, 0);
        check_int("glitch_errs", (cnt_ferr - f0) + (cnt_perr - p0), 0);
        check_int("glitch_busy_idle", int'(rx_busy), 0);
        total++;
        if (busy_cyc < 1 || busy_cyc > 10) begin
            bad++;
            $display("FAIL glitch_busy_len: got %0d cycles, want 1..10", busy_cyc);
        end
    endtask

    task automatic test_frame_error;
        int b0;
        int f0;
        int p0;
        b0 = cnt_byte;
        f0 = cnt_ferr;
        p0 = cnt_perr;
        send_frame(8'h55, ^8'h55, 1'b0);
        idle(40 * c_CPB);
        check_int("break_ferr", cnt_ferr - f0, 1);
        check_int("break_bytes", cnt_byte - b0, 0);
        check_int("break_perr", cnt_perr - p0, 0);
        check_int("break_data_kept", int'(reg_usb_data_in), 'hC3);
        check_int("break_busy", int'(rx_busy), 1);
        rx = 1'b1;
        idle(2 * c_CPB);
        check_int("break_released", int'(rx_busy), 0);
        check_int("break_ferr_final", cnt_ferr - f0, 1);
    endtask

    task automatic test_back_to_back;
        int b0;
        b0 = cnt_byte;
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h00);
        send_byte(8'h80);
        send_byte(8'h02);
        send_byte(8'h00);
        idle(2 * c_CPB);
        check_int("b2b_bytes", cnt_byte - b0, 3);
        check_int("b2b_data_last", int'(reg_usb_data_in), 'h00);
        check_int("b2b_queue_empty", exp_q.size(), 0);
    endtask

    task automatic test_reset_mid_frame;
        int b0;
        int f0;
        logic [7:0] d;
        b0 = cnt_byte;
        f0 = cnt_ferr;
        d  = 8'h3C;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        idle(c_CPB / 2);
        #2 reset = 1'b1;
        #1;
        check_int("midrst_data", int'(reg_usb_data_in), 0);
        check_int("midrst_busy", int'(rx_busy), 0);
        check_int("midrst_pulses", int'({byte_ready, frame_error, parity_error}), 0);
        rx = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2 * c_CPB);
        check_int("midrst_no_byte", cnt_byte - b0, 0);
        exp_q.push_back(8'hA5);
        send_byte(8'hA5);
        idle(c_CPB);
        check_int("a5_bytes", cnt_byte - b0, 1);
        check_int("a5_data", int'(reg_usb_data_in), 'hA5);
        check_int("a5_ferr", cnt_ferr - f0, 0);
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity;
        int b0;
        int p0;
        b0 = cnt_byte;
        p0 = cnt_perr;
        send_frame(8'h01, 1'b0, 1'b1);
        idle(c_CPB);
        check_int("par_bad_perr", cnt_perr - p0, 1);
        check_int("par_bad_bytes", cnt_byte - b0, 0);
        check_int("par_bad_data_kept", int'(reg_usb_data_in), 'hA5);
        exp_q.push_back(8'h03);
        send_frame(8'h03, 1'b0, 1'b1);
        idle(c_CPB);
        check_int("par_ok_bytes", cnt_byte - b0, 1);
        check_int("par_ok_data", int'(reg_usb_data_in), 'h03);
        check_int("par_ok_perr", cnt_perr - p0, 1);
    endtask
`endif

    initial begin
        total    = 0;
        bad      = 0;
        cnt_byte = 0;
        cnt_ferr = 0;
        cnt_perr = 0;
        busy_cyc = 0;
        rx       = 1'b1;
        reset    = 1'b1;
        test_reset();
        test_valid_byte();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        check_int("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
